p_mul_issue: RTL and testbench
==============================

// Module: p_mul_issue
//
// PURPOSE
//  Issue and response stage directly upstream of the packed multiplier.
//  - Accepts one packed multiply request per transaction through a valid/ready handshake.
//  - Decodes the operation and the binary pack width into the multiplier's one-hot controls.
//  - Holds the operands stable and keeps mul_valid high until the multiplier signals done.
//  - Captures the result into a response register held until writeback takes it.
//
// PARAMETERS
//  TAG_W   5   width of the opaque request tag returned with the response
//
// PORTS
//  clock       in   1      clock
//  resetn      in   1      synchronous, active-low reset
//  req_valid   in   1      request present
//  req_ready   out  1      request accepted when req_valid && req_ready
//  req_op      in   2      00 mul_l, 01 mul_h, 10 clmul, 11 illegal
//  req_pw      in   3      0:32 1:16 2:8 3:4 4:2 bit lanes; 5-7 illegal
//  req_rs1     in   32     packed operand 1
//  req_rs2     in   32     packed operand 2
//  req_tag     in   TAG_W  returned unchanged on rsp_tag
//  rsp_valid   out  1      response present
//  rsp_ready   in   1      response consumed when rsp_valid && rsp_ready
//  rsp_result  out  32     packed result
//  rsp_tag     out  TAG_W  tag of the request
//  rsp_err     out  1      illegal op/pw, or watchdog expiry
//  mul_valid   out  1      to multiplier valid
//  mul_ready   in   1      from multiplier; done, result valid this cycle
//  mul_l, mul_h, clmul  out 1 each   one-hot op to multiplier
//  mul_pw      out  5      one-hot width: [0]=32 [1]=16 [2]=8 [3]=4 [4]=2
//  mul_crs1, mul_crs2  out 32        latched operands
//  mul_result  in   32     multiplier result; sampled only when mul_ready=1
//
// BEHAVIOUR
//  - Reset values: state IDLE; rsp_valid=0, rsp_err=0, rsp_result=0, rsp_tag=0; mul_valid=0.
//    All latched operand and control registers reset to 0, so mul_pw=0 and mul_l/mul_h/clmul=0.
//  - FSM states:
//    - IDLE: req_ready=1. On accept, latch op, pw, rs1, rs2 and tag.
//      - Illegal op or pw: go to RESP with err=1, result=0; mul_valid is never raised.
//      - Otherwise go to BUSY.
//    - BUSY: req_ready=0, mul_valid=1, controls and operands stable.
//      - On mul_ready=1: capture mul_result, err=0, go to RESP.
//      - mul_valid drops on the same edge so the multiplier restarts clean.
//    - RESP: rsp_valid=1, outputs stable, req_ready=0.
//      - On rsp_ready=1: go to IDLE.
//      - No request is accepted in the same cycle as the response pops; IDLE is re-entered first.
//  - Latency: for an accept edge at cycle N and lane width W, BUSY lasts W+1 cycles.
//    rsp_valid is first seen at cycle N+W+2 (pw32: N+34, pw2: N+4).
//  - Watchdog: a 6-bit counter clears on entry to BUSY and counts each BUSY cycle.
//    - At count == W+3 without mul_ready: go to RESP with err=1, result=0, drop mul_valid.
//  - A mul_ready seen outside BUSY is ignored.
//  - rsp_ready held low leaves the response untouched indefinitely (backpressure).
//  - Reset mid-operation, in any state: return to reset values on the next edge.
//    No response is emitted for the aborted request.
//
// CONFIGURATION
//  P_MUL_ZERO_SKIP_EN
//  - Defined: a legal request with rs1==0 or rs2==0 goes IDLE->RESP directly.
//    - Sets result=0, err=0; rsp_valid at N+1; mul_valid is never raised.
//    - Applies to every op.
//  - Undefined: all legal requests go through BUSY.
//
// STRUCTURE
//  - Package p_mul_pkg holds:
//    - op encodings (P_MUL_OP_*) and pw encodings (P_MUL_PW_*);
//    - a function mapping pw to the one-hot width and to W;
//    - the 2-bit state encoding (IDLE/BUSY/RESP).
//  - No sub-module. The multiplier is instantiated beside this block by the parent and wired
//    port-to-port.
//
// TESTING
//  1. mul_l, pw=0, rs1=3, rs2=5, accept at N
//     -> mul_valid for 33 cycles; rsp_result=0x0000000F, err=0, rsp_valid at N+34.
//  2. mul_l, pw=2, rs1=0x10FF0203, rs2=0x02FF0304
//     -> rsp_result=0x2001060C at N+10; tag echoed.
//  3. mul_h, pw=1, rs1=0xFFFF0002, rs2=0xFFFF0003
//     -> rsp_result=0xFFFE0000; mul_pw=5'b00010 throughout BUSY.
//  4. pw=5 or op=11 -> rsp_valid at N+1 with err=1, result=0; mul_valid stays 0.
//  5. rsp_ready low for 10 cycles after rsp_valid -> result and tag stable, req_ready=0.
//     Pop, then the next request is accepted one cycle later.
//  6. resetn low mid-BUSY (pw=0, cycle 10) -> next cycle IDLE, mul_valid=0, rsp_valid=0.
//     Variants:
//     - Watchdog: multiplier model never asserts mul_ready -> err=1 at N+W+4.
//     - With P_MUL_ZERO_SKIP_EN: rs2=0 -> result 0 at N+1, mul_valid never raised.

Source files
------------

// File: rtl/p_mul_pkg.sv
// p_mul_pkg: op/width encodings, FSM state encoding and width helpers for p_mul_issue.
package p_mul_pkg;
  localparam logic [1:0] P_MUL_OP_MUL_L = 2'b00;
  localparam logic [1:0] P_MUL_OP_MUL_H = 2'b01;
  localparam logic [1:0] P_MUL_OP_CLMUL = 2'b10;
  localparam logic [1:0] P_MUL_OP_ILL   = 2'b11;
  localparam logic [2:0] P_MUL_PW_32 = 3'd0;
  localparam logic [2:0] P_MUL_PW_16 = 3'd1;
  localparam logic [2:0] P_MUL_PW_8  = 3'd2;
  localparam logic [2:0] P_MUL_PW_4  = 3'd3;
  localparam logic [2:0] P_MUL_PW_2  = 3'd4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  function automatic logic [4:0] pw_onehot(input logic [2:0] pw);
    return pw <= P_MUL_PW_2 ? 5'b1 << pw : 5'b0;
  endfunction
  // Lane width W recovered from the one-hot control; 0 when no width is selected.
  function automatic logic [5:0] pw_lanes(input logic [4:0] oh);
    return oh[0] ? 6'd32 : oh[1] ? 6'd16 : oh[2] ? 6'd8 : oh[3] ? 6'd4 : oh[4] ? 6'd2 : 6'd0;
  endfunction
endpackage

// File: rtl/p_mul_issue.sv
// p_mul_issue: issue/response stage in front of the packed multiplier.
// Define P_MUL_ZERO_SKIP_EN to answer legal requests with a zero operand without the multiplier.
module p_mul_issue import p_mul_pkg::*; #(
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [2:0]       req_pw,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             mul_valid,
  input  logic             mul_ready,
  output logic             mul_l,
  output logic             mul_h,
  output logic             clmul,
  output logic [4:0]       mul_pw,
  output logic [31:0]      mul_crs1,
  output logic [31:0]      mul_crs2,
  input  logic [31:0]      mul_result
);
  logic [1:0] state;
  logic [5:0] cnt;
  logic legal, zero, expire;
  assign legal = req_op != P_MUL_OP_ILL && req_pw <= P_MUL_PW_2;
`ifdef P_MUL_ZERO_SKIP_EN
  assign zero = req_rs1 == '0 || req_rs2 == '0;
`else
  assign zero = 1'b0;
`endif
  assign req_ready = state == S_IDLE;
  assign mul_valid = state == S_BUSY;
  assign rsp_valid = state == S_RESP;
  // Watchdog fires in the cycle that brings the BUSY count to W+3.
  assign expire = cnt == pw_lanes(mul_pw) + 6'd2;
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      mul_l      <= 1'b0;
      mul_h      <= 1'b0;
      clmul      <= 1'b0;
      mul_pw     <= '0;
      mul_crs1   <= '0;
      mul_crs2   <= '0;
      rsp_result <= '0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          mul_l      <= req_op == P_MUL_OP_MUL_L;
          mul_h      <= req_op == P_MUL_OP_MUL_H;
          clmul      <= req_op == P_MUL_OP_CLMUL;
          mul_pw     <= pw_onehot(req_pw);
          mul_crs1   <= req_rs1;
          mul_crs2   <= req_rs2;
          rsp_tag    <= req_tag;
          rsp_result <= '0;
          rsp_err    <= !legal;
          cnt        <= '0;
          state      <= legal && !zero ? S_BUSY : S_RESP;
        end
        S_BUSY: begin
          cnt <= cnt + 6'd1;
          if (mul_ready) begin
            rsp_result <= mul_result;
            rsp_err    <= 1'b0;
            state      <= S_RESP;
          end else if (expire) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_RESP: if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_p_mul_issue.sv
// tb_p_mul_issue: scoreboard bench with a cycle-accurate packed multiplier model beside the DUT.
module tb_p_mul_issue;
  logic clock = 1'b0;
  logic resetn;
  logic req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [1:0] req_op;
  logic [2:0] req_pw;
  logic [31:0] req_rs1, req_rs2, rsp_result, mul_crs1, mul_crs2, mul_result;
  logic [4:0] req_tag, rsp_tag, mul_pw;
  logic mul_valid, mul_ready, mul_l, mul_h, clmul;
  logic hang = 1'b0;
  logic noise_rdy = 1'b0;
  logic [31:0] noise_res = '0;
  logic prv = 1'b0;
  int cyc = 0;
  int mc = 0;
  int dop, dpw, dw;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res, a, b;
    logic [4:0]  tag;
    logic [2:0]  pw;
    logic        err, busy;
    int          acc, lat;
  } ent_t;
  ent_t q[$];

  p_mul_issue #(.TAG_W(5)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_pw(req_pw),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_l(mul_l), .mul_h(mul_h),
    .clmul(clmul), .mul_pw(mul_pw), .mul_crs1(mul_crs1), .mul_crs2(mul_crs2),
    .mul_result(mul_result)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Packed lane multiply: op 0 low half, 1 high half (unsigned), 2 carry-less low half.
  function automatic logic [31:0] ref_mul(input int op, input int pw, input logic [31:0] a, input logic [31:0] b);
    int w = 32 >> pw;
    logic [31:0] r = '0;
    logic [63:0] x, y, p, mask;
    if (op == 3) return 32'hBAD0BAD0;
    mask = (64'd1 << w) - 64'd1;
    for (int l = 0; l < 32 / w; l++) begin
      x = 64'(a >> (l * w)) & mask;
      y = 64'(b >> (l * w)) & mask;
      p = '0;
      if (op == 2) begin
        for (int i = 0; i < w; i++) if (y[i]) p = p ^ (x << i);
      end else p = x * y;
      if (op == 1) p = p >> w;
      r = r | 32'((p & mask) << (l * w));
    end
    return r;
  endfunction

  // Multiplier model: driven only by the controls the DUT presents; done after W+1 valid cycles.
  always_comb begin
    dop = mul_l ? 0 : mul_h ? 1 : clmul ? 2 : 3;
    dpw = 0;
    dw = 0;
    for (int i = 0; i < 5; i++) if (mul_pw[i]) begin dpw = i; dw = 32 >> i; end
  end
  assign mul_ready  = mul_valid ? (!hang && mc == dw) : noise_rdy;
  assign mul_result = mul_valid ? ref_mul(dop, dpw, mul_crs1, mul_crs2) : noise_res;
  always @(posedge clock) begin
    mc <= mul_valid ? mc + 1 : 0;
    noise_rdy <= 1'($urandom_range(1));
    noise_res <= $urandom;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (!resetn) prv <= 1'b0;
    else begin
      if (mul_valid) begin
        if (q.size() == 0 || !q[0].busy) chk("mul_valid raised", 1, 0);
        else begin
          chk("mul_pw", 64'(mul_pw), 64'(5'b1 << q[0].pw));
          chk("mul_crs1", 64'(mul_crs1), 64'(q[0].a));
          chk("mul_crs2", 64'(mul_crs2), 64'(q[0].b));
        end
      end
      if (rsp_valid) begin
        if (q.size() == 0) chk("rsp without request", 1, 0);
        else begin
          if (!prv) chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
          chk("rsp_result", 64'(rsp_result), 64'(q[0].res));
          chk("rsp_tag", 64'(rsp_tag), 64'(q[0].tag));
          chk("rsp_err", 64'(rsp_err), 64'(q[0].err));
          chk("req_ready in resp", 64'(req_ready), 0);
          if (rsp_ready) void'(q.pop_front());
        end
      end
      prv <= rsp_valid;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [2:0] pw, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag, input logic hg,
                       input logic [31:0] exp_res, output logic ok);
    ent_t e;
    int t = 0;
    logic legal, zs;
    int w;
    hang = hg;
    @(posedge clock); #1;
    req_valid = 1'b1; req_op = op; req_pw = pw; req_rs1 = a; req_rs2 = b; req_tag = tag;
    while (!req_ready && t < 100) begin @(posedge clock); #1; t++; end
    ok = req_ready;
    if (!ok) begin chk("accept timeout", 0, 1); req_valid = 1'b0; return; end
    legal = op != 2'b11 && pw < 3'd5;
    w = legal ? 32 >> pw : 0;
    zs = 1'b0;
`ifdef P_MUL_ZERO_SKIP_EN
    zs = a == 0 || b == 0;
`endif
    e.a = a; e.b = b; e.tag = tag; e.pw = pw; e.acc = cyc;
    if (!legal) begin e.res = 0; e.err = 1; e.lat = 1; e.busy = 0; end
    else if (zs) begin e.res = 0; e.err = 0; e.lat = 1; e.busy = 0; end
    else if (hg) begin e.res = 0; e.err = 1; e.lat = w + 4; e.busy = 1; end
    else begin e.res = exp_res; e.err = 0; e.lat = w + 2; e.busy = 1; end
    q.push_back(e);
    @(posedge clock); #1;
    req_valid = 1'b0; req_rs1 = $urandom; req_rs2 = $urandom; req_tag = 5'($urandom);
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] pw, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] tag, input logic hg,
                      input int hold, input logic [31:0] exp_res);
    int t = 0;
    logic ok;
    issue(op, pw, a, b, tag, hg, exp_res, ok);
    if (!ok) return;
    while (!rsp_valid && t < 100) begin @(posedge clock); #1; t++; end
    if (!rsp_valid) begin chk("response timeout", 0, 1); q.delete(); return; end
    repeat (hold) @(posedge clock);
    #1;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    chk("req_ready after pop", 64'(req_ready), 1);
    chk("rsp_valid after pop", 64'(rsp_valid), 0);
    chk("scoreboard drained", 64'(q.size()), 0);
  endtask

  initial begin
    logic ok;
    logic [1:0] op;
    logic [2:0] pw;
    logic [31:0] a, b;
    resetn = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_pw = '0; req_rs1 = '0; req_rs2 = '0; req_tag = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset req_ready", 64'(req_ready), 1);
    chk("reset rsp_valid", 64'(rsp_valid), 0);
    chk("reset mul_valid", 64'(mul_valid), 0);
    chk("reset rsp_result", 64'(rsp_result), 0);
    chk("reset rsp_tag", 64'(rsp_tag), 0);
    chk("reset rsp_err", 64'(rsp_err), 0);
    chk("reset mul_pw", 64'(mul_pw), 0);
    chk("reset ops", 64'({mul_l, mul_h, clmul}), 0);
    resetn = 1'b1;
    send(2'b00, 3'd0, 32'd3, 32'd5, 5'h01, 1'b0, 0, 32'h0000000F);
    send(2'b00, 3'd2, 32'h10FF0203, 32'h02FF0304, 5'h15, 1'b0, 1, 32'h2001060C);
    send(2'b01, 3'd1, 32'hFFFF0002, 32'hFFFF0003, 5'h0A, 1'b0, 0, 32'hFFFE0000);
    send(2'b00, 3'd5, 32'h1234, 32'h5678, 5'h1F, 1'b0, 0, 32'h0);
    send(2'b11, 3'd0, 32'h1234, 32'h5678, 5'h11, 1'b0, 2, 32'h0);
    send(2'b10, 3'd3, 32'hA5A5F00F, 32'h3C3C0FF1, 5'h07, 1'b0, 10, ref_mul(2, 3, 32'hA5A5F00F, 32'h3C3C0FF1));
    send(2'b00, 3'd4, 32'd7, 32'd9, 5'h02, 1'b1, 0, 32'h0);
    send(2'b01, 3'd0, 32'h7, 32'h9, 5'h03, 1'b1, 1, 32'h0);
    send(2'b10, 3'd2, 32'h1234, 32'h0, 5'h04, 1'b0, 0, 32'h0);
    // Abort a pw32 request ten cycles into BUSY.
    issue(2'b00, 3'd0, 32'd3, 32'd5, 5'h09, 1'b0, 32'hF, ok);
    repeat (9) @(posedge clock);
    #1;
    resetn = 1'b0;
    q.delete();
    @(posedge clock); #1;
    chk("abort mul_valid", 64'(mul_valid), 0);
    chk("abort rsp_valid", 64'(rsp_valid), 0);
    chk("abort req_ready", 64'(req_ready), 1);
    chk("abort rsp_tag", 64'(rsp_tag), 0);
    resetn = 1'b1;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(3));
      pw = 3'($urandom_range(6));
      a = $urandom_range(7) == 0 ? 32'h0 : $urandom;
      b = $urandom_range(7) == 0 ? 32'h0 : $urandom;
      send(op, pw, a, b, 5'($urandom), $urandom_range(7) == 0, $urandom_range(3),
           pw < 3'd5 ? ref_mul(int'(op), int'(pw), a, b) : 32'h0);
    end
    repeat (2) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
